// File: rtl/rotate_pkg.sv
// Shared AHB-Lite encodings and helpers for the rotate engine DMA path.
// Holds bus constants, DMA state encoding and request legality check.
package rotate_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned KB_BOUND = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ADDR,
        ST_BURST,
        ST_DRAIN,
        ST_ERR
    } dma_state_t;

    function automatic logic [2:0] burst_of(input int beats);
        logic [2:0] b;
        case (beats)
            8:       b = HBURST_INCR8;
            4:       b = HBURST_INCR4;
            1:       b = HBURST_SINGLE;
            default: b = HBURST_INCR;
        endcase
        return b;
    endfunction

    // Rejects oversize beats, misaligned starts and 1 KB crossings.
    function automatic logic req_bad(
        input logic [9:0] lo,
        input logic [2:0] size,
        input int         beats
    );
        logic [15:0] mask;
        logic [15:0] last;
        logic        bad;
        mask = (16'd1 << size) - 16'd1;
        last = 16'(lo) + (16'(beats) << size) - 16'd1;
        bad  = (size > HSIZE_WORD)
             || ((16'(lo) & mask) != 16'd0)
             || (last >= 16'(KB_BOUND));
        return bad;
    endfunction

endpackage

// File: rtl/ahb_beat_ctr.sv
// Beat bookkeeping for one burst: issued and completed beat counts,
// the running address and last-beat flags.
module ahb_beat_ctr
    import rotate_pkg::*;
#(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_LOAD,
    input  logic [ADDR_W-1:0] I_ADDR,
    input  logic [2:0]        I_SIZE,
    input  logic              I_ISSUE,
    input  logic              I_DONE,
    output logic [ADDR_W-1:0] O_ADDR,
    output logic [2:0]        O_SIZE,
    output logic              O_LAST_ADDR,
    output logic              O_LAST_DATA
);

    localparam int CW = $clog2(BEATS) + 1;

    logic [CW-1:0]     issued_q;
    logic [CW-1:0]     done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            issued_q <= '0;
            done_q   <= '0;
            addr_q   <= '0;
            size_q   <= HSIZE_BYTE;
        end else if (I_LOAD) begin
            issued_q <= '0;
            done_q   <= '0;
            addr_q   <= I_ADDR;
            size_q   <= I_SIZE;
        end else begin
            if (I_ISSUE) begin
                issued_q <= issued_q + CW'(1);
                addr_q   <= addr_q + (ADDR_W'(1) << size_q);
            end
            if (I_DONE) begin
                done_q <= done_q + CW'(1);
            end
        end
    end

    assign O_ADDR      = addr_q;
    assign O_SIZE      = size_q;
    assign O_LAST_ADDR = (issued_q == CW'(BEATS - 1));
    assign O_LAST_DATA = (done_q == CW'(BEATS - 1));

endmodule

// File: rtl/core_dma.sv
// AHB-Lite burst master serving core_set pixel-set requests.
// One request becomes one fixed-length incrementing burst.
module core_dma
    import rotate_pkg::*;
#(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    input  logic [2:0]        I_SIZE,
    input  logic              I_WRITE,
    input  logic [DATA_W-1:0] I_WDATA,
    output logic              O_DMA_READY,
    output logic [DATA_W-1:0] O_RDATA,
    output logic              O_BUSY,
    output logic              O_ERR,
    output logic [ADDR_W-1:0] O_HADDR,
    output logic [1:0]        O_HTRANS,
    output logic              O_HWRITE,
    output logic [2:0]        O_HSIZE,
    output logic [2:0]        O_HBURST,
    output logic [DATA_W-1:0] O_HWDATA,
    input  logic [DATA_W-1:0] I_HRDATA,
    input  logic              I_HREADY,
    input  logic              I_HRESP
);

    localparam logic [2:0] BURST_T = burst_of(BEATS);

    dma_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic              write_q;
    logic              dphase_q;
    logic              rdy_q;
    logic [DATA_W-1:0] rdata_q;

    logic              load, issue, err;
    logic              err_hit, beat_done;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              last_addr, last_data;

    ahb_beat_ctr #(
        .BEATS  (BEATS),
        .ADDR_W (ADDR_W)
    ) u_ctr (
        .I_HCLK      (I_HCLK),
        .I_HRESET    (I_HRESET),
        .I_LOAD      (load),
        .I_ADDR      (I_ADDR),
        .I_SIZE      (I_SIZE),
        .I_ISSUE     (issue),
        .I_DONE      (beat_done),
        .O_ADDR      (addr),
        .O_SIZE      (size),
        .O_LAST_ADDR (last_addr),
        .O_LAST_DATA (last_data)
    );

    assign err_hit   = dphase_q & I_HRESP;
    assign beat_done = dphase_q & I_HREADY & ~I_HRESP;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        issue   = 1'b0;
        err     = 1'b0;
        htrans  = HTRANS_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (I_REQ && !busy_q) begin
                    load    = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = req_bad(addr[9:0], size, BEATS) ? ST_ERR : ST_ADDR;
            end
            ST_ADDR: begin
                htrans = HTRANS_NONSEQ;
                if (I_HREADY) begin
                    issue   = 1'b1;
                    state_d = last_addr ? ST_DRAIN : ST_BURST;
                end
            end
            ST_BURST: begin
                // First ERROR cycle: cancel the pending address phase.
                if (err_hit) begin
                    state_d = ST_ERR;
                end else begin
                    htrans = HTRANS_SEQ;
                    if (I_HREADY) begin
                        issue   = 1'b1;
                        state_d = last_addr ? ST_DRAIN : ST_BURST;
                    end
                end
            end
            ST_DRAIN: begin
                if (err_hit) begin
                    state_d = ST_ERR;
                end else if (beat_done && last_data) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = load | (busy_q & (state_d != ST_IDLE));

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            write_q  <= 1'b0;
            dphase_q <= 1'b0;
            rdy_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (load) begin
                write_q <= I_WRITE;
            end
            if (I_HREADY || err_hit) begin
                dphase_q <= issue;
            end
            rdy_q <= beat_done & ~write_q;
            if (beat_done && !write_q) begin
                rdata_q <= I_HRDATA;
            end
        end
    end

    assign O_DMA_READY = rdy_q | (beat_done & write_q);
    assign O_RDATA     = rdata_q;
    assign O_BUSY      = busy_q;
    assign O_ERR       = err;
    assign O_HTRANS    = htrans;
    assign O_HADDR     = (htrans != HTRANS_IDLE) ? addr : '0;
    assign O_HWRITE    = (htrans != HTRANS_IDLE) & write_q;
    assign O_HSIZE     = (htrans != HTRANS_IDLE) ? size : 3'b000;
    assign O_HBURST    = (htrans != HTRANS_IDLE) ? BURST_T : 3'b000;
    assign O_HWDATA    = (dphase_q && write_q) ? I_WDATA : '0;

endmodule

// File: tb/tb_core_dma.sv
// Directed bench for core_dma: reads, writes with waits, rejects,
// bus errors, reset mid-burst and back-to-back requests.
module tb_core_dma;

    logic        I_HCLK;
    logic        I_HRESET;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [2:0]  I_SIZE;
    logic        I_WRITE;
    logic [31:0] I_WDATA;
    logic        O_DMA_READY;
    logic [31:0] O_RDATA;
    logic        O_BUSY;
    logic        O_ERR;
    logic [31:0] O_HADDR;
    logic [1:0]  O_HTRANS;
    logic        O_HWRITE;
    logic [2:0]  O_HSIZE;
    logic [2:0]  O_HBURST;
    logic [31:0] O_HWDATA;
    logic [31:0] I_HRDATA;
    logic        I_HREADY;
    logic        I_HRESP;

    int n_cmp = 0;
    int n_bad = 0;

    core_dma dut (
        .I_HCLK      (I_HCLK),
        .I_HRESET    (I_HRESET),
        .I_REQ       (I_REQ),
        .I_ADDR      (I_ADDR),
        .I_SIZE      (I_SIZE),
        .I_WRITE     (I_WRITE),
        .I_WDATA     (I_WDATA),
        .O_DMA_READY (O_DMA_READY),
        .O_RDATA     (O_RDATA),
        .O_BUSY      (O_BUSY),
        .O_ERR       (O_ERR),
        .O_HADDR     (O_HADDR),
        .O_HTRANS    (O_HTRANS),
        .O_HWRITE    (O_HWRITE),
        .O_HSIZE     (O_HSIZE),
        .O_HBURST    (O_HBURST),
        .O_HWDATA    (O_HWDATA),
        .I_HRDATA    (I_HRDATA),
        .I_HREADY    (I_HREADY),
        .I_HRESP     (I_HRESP)
    );

    initial begin
        I_HCLK = 1'b0;
        forever #5 I_HCLK = ~I_HCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge I_HCLK);
        #2;
    endtask

    task automatic start(input logic [31:0] a, input logic [2:0] s,
                         input logic w);
        cyc();
        I_REQ   = 1'b1;
        I_ADDR  = a;
        I_SIZE  = s;
        I_WRITE = w;
    endtask

    initial begin
        logic [31:0] et, ea, ed;
        logic        er;
        int          nr, ne, w;

        I_HRESET = 1'b1;
        I_REQ    = 1'b0;
        I_ADDR   = '0;
        I_SIZE   = 3'd2;
        I_WRITE  = 1'b0;
        I_WDATA  = '0;
        I_HRDATA = '0;
        I_HREADY = 1'b1;
        I_HRESP  = 1'b0;
        repeat (2) @(posedge I_HCLK);
        #2 I_HRESET = 1'b0;
        #1;
        chk("rst htrans", 32'(O_HTRANS), 32'd0);
        chk("rst haddr", O_HADDR, 32'd0);
        chk("rst busy", 32'(O_BUSY), 32'd0);
        chk("rst ready", 32'(O_DMA_READY), 32'd0);
        chk("rst err", 32'(O_ERR), 32'd0);
        chk("rst rdata", O_RDATA, 32'd0);

        // Zero-wait read at 0x100.
        start(32'h100, 3'd2, 1'b0);
        nr = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            I_REQ    = 1'b0;
            I_HRDATA = (c >= 3 && c <= 10) ? 32'(32'hA0 + c - 3) : 32'hDEADBEEF;
            #1;
            et = (c == 2) ? 32'd2 : (c >= 3 && c <= 9) ? 32'd3 : 32'd0;
            chk($sformatf("rd htrans c%0d", c), 32'(O_HTRANS), et);
            if (et != 0) begin
                ea = 32'(32'h100 + 4 * (c - 2));
                chk($sformatf("rd haddr c%0d", c), O_HADDR, ea);
            end
            if (c == 2) begin
                chk("rd hburst", 32'(O_HBURST), 32'h5);
                chk("rd hsize", 32'(O_HSIZE), 32'h2);
                chk("rd hwrite", 32'(O_HWRITE), 32'h0);
            end
            er = (c >= 4 && c <= 11);
            chk($sformatf("rd ready c%0d", c), 32'(O_DMA_READY), 32'(er));
            if (er) begin
                ed = 32'(32'hA0 + c - 4);
                chk($sformatf("rd rdata c%0d", c), O_RDATA, ed);
            end
            chk($sformatf("rd err c%0d", c), 32'(O_ERR), 32'd0);
            chk($sformatf("rd busy c%0d", c), 32'(O_BUSY), 32'(c <= 10));
            if (O_DMA_READY) nr++;
        end
        chk("rd pulses", 32'(nr), 32'd8);

        // Write at 0x200, two wait states on the data phase of beat 3.
        start(32'h200, 3'd2, 1'b1);
        w = 0;
        I_WDATA = 32'hD0;
        nr = 0;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            I_REQ    = 1'b0;
            I_HREADY = !(c == 6 || c == 7);
            I_WDATA  = 32'(32'hD0 + w);
            #1;
            et = (c == 2) ? 32'd2 : (c >= 3 && c <= 11) ? 32'd3 : 32'd0;
            chk($sformatf("wr htrans c%0d", c), 32'(O_HTRANS), et);
            if (c >= 2 && c <= 5) ea = 32'(32'h200 + 4 * (c - 2));
            else if (c >= 6 && c <= 8) ea = 32'h210;
            else ea = 32'(32'h214 + 4 * (c - 9));
            if (et != 0) chk($sformatf("wr haddr c%0d", c), O_HADDR, ea);
            if (c >= 3 && c <= 5) ed = 32'(32'hD0 + c - 3);
            else if (c >= 6 && c <= 8) ed = 32'hD3;
            else if (c >= 9 && c <= 12) ed = 32'(32'hD4 + c - 9);
            else ed = 32'd0;
            chk($sformatf("wr hwdata c%0d", c), O_HWDATA, ed);
            er = (c inside {3, 4, 5, 8, 9, 10, 11, 12});
            chk($sformatf("wr ready c%0d", c), 32'(O_DMA_READY), 32'(er));
            chk($sformatf("wr busy c%0d", c), 32'(O_BUSY), 32'(c <= 12));
            if (O_DMA_READY) begin
                nr++;
                w++;
            end
        end
        chk("wr pulses", 32'(nr), 32'd8);
        I_HREADY = 1'b1;

        // Burst 0x3F0..0x40F crosses a 1 KB boundary.
        start(32'h3F0, 3'd2, 1'b0);
        ne = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            I_REQ = 1'b0;
            #1;
            chk($sformatf("rej htrans c%0d", c), 32'(O_HTRANS), 32'd0);
            chk($sformatf("rej ready c%0d", c), 32'(O_DMA_READY), 32'd0);
            chk($sformatf("rej err c%0d", c), 32'(O_ERR), 32'(c == 2));
            chk($sformatf("rej busy c%0d", c), 32'(O_BUSY), 32'(c <= 2));
            if (O_ERR) ne++;
        end
        chk("rej err pulses", 32'(ne), 32'd1);

        // Read with an ERROR response on the 5th beat.
        start(32'h100, 3'd2, 1'b0);
        nr = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            I_REQ    = 1'b0;
            I_HRDATA = (c >= 3 && c <= 6) ? 32'(32'hB0 + c - 3) : 32'hDEADBEEF;
            I_HRESP  = (c == 7 || c == 8);
            I_HREADY = (c != 7);
            #1;
            et = (c == 2) ? 32'd2 : (c >= 3 && c <= 6) ? 32'd3 : 32'd0;
            chk($sformatf("be htrans c%0d", c), 32'(O_HTRANS), et);
            er = (c >= 4 && c <= 7);
            chk($sformatf("be ready c%0d", c), 32'(O_DMA_READY), 32'(er));
            if (er) begin
                ed = 32'(32'hB0 + c - 4);
                chk($sformatf("be rdata c%0d", c), O_RDATA, ed);
            end
            chk($sformatf("be err c%0d", c), 32'(O_ERR), 32'(c == 8));
            chk($sformatf("be busy c%0d", c), 32'(O_BUSY), 32'(c <= 8));
            if (O_DMA_READY) nr++;
        end
        chk("be pulses", 32'(nr), 32'd4);
        I_HRESP  = 1'b0;
        I_HREADY = 1'b1;

        // Reset asserted during the 4th beat of a read.
        start(32'h100, 3'd2, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            I_REQ    = 1'b0;
            I_HRDATA = 32'(32'hC0 + c - 3);
            I_HRESET = (c == 6);
            #1;
        end
        chk("mid htrans before", 32'(O_HTRANS), 32'd3);
        cyc();
        I_HRESET = 1'b0;
        #1;
        chk("mid htrans", 32'(O_HTRANS), 32'd0);
        chk("mid haddr", O_HADDR, 32'd0);
        chk("mid hburst", 32'(O_HBURST), 32'd0);
        chk("mid hsize", 32'(O_HSIZE), 32'd0);
        chk("mid hwrite", 32'(O_HWRITE), 32'd0);
        chk("mid hwdata", O_HWDATA, 32'd0);
        chk("mid busy", 32'(O_BUSY), 32'd0);
        chk("mid err", 32'(O_ERR), 32'd0);
        chk("mid ready", 32'(O_DMA_READY), 32'd0);
        chk("mid rdata", O_RDATA, 32'd0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk($sformatf("mid quiet %0d", c), 32'(O_DMA_READY | O_ERR), 32'd0);
        end

        // Clean zero-wait write after the reset.
        start(32'h40, 3'd2, 1'b1);
        w = 0;
        nr = 0;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            I_REQ   = 1'b0;
            I_WDATA = 32'(32'h50 + w);
            #1;
            er = (c >= 3 && c <= 10);
            chk($sformatf("pw ready c%0d", c), 32'(O_DMA_READY), 32'(er));
            if (er) begin
                ed = 32'(32'h50 + c - 3);
                chk($sformatf("pw hwdata c%0d", c), O_HWDATA, ed);
            end
            chk($sformatf("pw busy c%0d", c), 32'(O_BUSY), 32'(c <= 10));
            if (O_DMA_READY) begin
                nr++;
                w++;
            end
        end
        chk("pw pulses", 32'(nr), 32'd8);

        // Back-to-back reads at 0x000 and 0x020 with I_REQ held high.
        start(32'h0, 3'd2, 1'b0);
        nr = 0;
        for (int c = 1; c <= 24; c++) begin
            cyc();
            if (c == 1) I_ADDR = 32'h20;
            if (c == 12) I_REQ = 1'b0;
            if (c >= 3 && c <= 10) I_HRDATA = 32'(32'hE0 + c - 3);
            else if (c >= 14 && c <= 21) I_HRDATA = 32'(32'hE8 + c - 14);
            else I_HRDATA = 32'hDEADBEEF;
            #1;
            if (c == 2 || c == 13) et = 32'd2;
            else if ((c >= 3 && c <= 9) || (c >= 14 && c <= 20)) et = 32'd3;
            else et = 32'd0;
            chk($sformatf("bb htrans c%0d", c), 32'(O_HTRANS), et);
            ea = (c <= 9) ? 32'(4 * (c - 2)) : 32'(32'h20 + 4 * (c - 13));
            if (et != 0) chk($sformatf("bb haddr c%0d", c), O_HADDR, ea);
            er = (c >= 4 && c <= 11) || (c >= 15 && c <= 22);
            chk($sformatf("bb ready c%0d", c), 32'(O_DMA_READY), 32'(er));
            if (er) begin
                ed = (c <= 11) ? 32'(32'hE0 + c - 4) : 32'(32'hE8 + c - 15);
                chk($sformatf("bb rdata c%0d", c), O_RDATA, ed);
            end
            chk($sformatf("bb busy c%0d", c), 32'(O_BUSY),
                32'((c <= 10) || (c >= 12 && c <= 21)));
            if (O_DMA_READY) nr++;
        end
        chk("bb pulses", 32'(nr), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_dma.md
Name: core_dma

Overview:
- AHB-Lite master that services the pixel-set address requests issued by the rotate address generator (core_set).
- Each request is one 8-beat burst, read or write, at a given address and size.
- The block converts the request into an INCR8 AHB transaction.
- It returns a per-beat ready strobe that the requester uses to advance its set and burst counters.
- Read data is passed back to the requester; write data is taken from the requester.

Parameters:
- BEATS, 8, beats per request; sets HBURST (8 -> INCR8, 4 -> INCR4, 1 -> SINGLE).
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width.

Ports:
- I_HCLK  in  1  bus clock
- I_HRESET  in  1  synchronous active-high reset
- I_REQ  in  1  request valid (requester busy)
- I_ADDR  in  ADDR_W  burst start byte address
- I_SIZE  in  3  beat size, AHB HSIZE encoding
- I_WRITE  in  1  1 = write burst, 0 = read burst
- I_WDATA  in  DATA_W  write beat data; requester advances on O_DMA_READY
- O_DMA_READY  out  1  one data beat completed this cycle
- O_RDATA  out  DATA_W  read beat data, valid with O_DMA_READY on reads
- O_BUSY  out  1  request accepted and not finished
- O_ERR  out  1  one-cycle pulse: bus error or rejected request
- O_HADDR  out  ADDR_W  AHB address
- O_HTRANS  out  2  AHB transfer type
- O_HWRITE  out  1  AHB write
- O_HSIZE  out  3  AHB size
- O_HBURST  out  3  AHB burst type
- O_HWDATA  out  DATA_W  AHB write data
- I_HRDATA  in  DATA_W  AHB read data
- I_HREADY  in  1  AHB ready
- I_HRESP  in  1  AHB response (1 = ERROR)

Behaviour:
- Clock and reset: single clock domain, I_HCLK. I_HRESET is synchronous, active-high, and applies at the next clock edge.
- Reset values: every output 0; O_HTRANS = IDLE (2'b00); state IDLE; counters 0.
- Reset mid-burst: bus returns to IDLE on the next edge. No O_ERR pulse and no further O_DMA_READY.
- States: IDLE, CHECK, ADDR, BURST, DRAIN, ERR.
- IDLE: when I_REQ = 1 and O_BUSY = 0, register I_ADDR, I_SIZE and I_WRITE, set O_BUSY, and go to CHECK.
- CHECK (1 cycle):
  - Reject if I_SIZE > 2, if the address is not aligned to (1 << size), or if start + BEATS*(1 << size) - 1 crosses a 1 KB boundary.
  - On reject: go to ERR.
  - Otherwise: go to ADDR.
- ADDR: drive O_HTRANS = NONSEQ, O_HBURST per BEATS, and O_HSIZE / O_HWRITE from the registered request. Hold until I_HREADY = 1, then go to BURST.
- BURST:
  - Drive O_HTRANS = SEQ.
  - O_HADDR increments by (1 << size) on each I_HREADY = 1 address-phase completion.
  - The address phase of beat n overlaps the data phase of beat n-1.
  - After BEATS address phases have been issued, drive O_HTRANS = IDLE and go to DRAIN.
- DRAIN: wait for the final data phase. On its I_HREADY = 1, clear O_BUSY and go to IDLE.
- Beat completion: O_DMA_READY = 1 exactly in cycles where a data phase is active and I_HREADY = 1, giving exactly BEATS pulses per accepted request.
  - Read: O_RDATA = I_HRDATA, registered together with O_DMA_READY so both are visible in the same cycle, one cycle after the HREADY edge.
  - Write: O_HWDATA = I_WDATA combinationally during a write data phase, otherwise 0. The requester must present beat k until the k-th O_DMA_READY.
- Latency (zero-wait bus):
  - Acceptance edge = cycle 0; NONSEQ at cycle 2.
  - Read O_DMA_READY pulses at cycles 4..11.
  - Write O_DMA_READY pulses at cycles 3..10.
  - O_BUSY falls after the last pulse.
- Wait states (I_HREADY = 0): hold O_HADDR, O_HTRANS and O_HWDATA; no O_DMA_READY.
- Error (I_HRESP = 1):
  - Cycle 1 of the two-cycle ERROR response: force O_HTRANS = IDLE.
  - Second cycle: pulse O_ERR, clear O_BUSY, go to IDLE.
  - The beat in error is not counted as complete.
- ERR state: pulse O_ERR for 1 cycle, no bus activity, clear O_BUSY, go to IDLE.
- I_REQ while O_BUSY = 1: ignored. A request held high after completion starts a new burst, which is the back-to-back case.
- Counters: issued-beat and completed-beat counters, each $clog2(BEATS)+1 bits wide, no wrap. Address arithmetic is ADDR_W bits; no carry past the 1 KB window, by construction of the CHECK state.

Decomposition:
- Package rotate_pkg:
  - HTRANS constants: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST constants: SINGLE, INCR4, INCR8.
  - HSIZE constants: BYTE, HALF, WORD.
  - core_dma state encodings.
  - The 1 KB boundary constant.
- One natural sub-module, ahb_beat_ctr: issued/completed beat counting plus address increment, with a last-address / last-data flag output.

Test Plan:
- Zero-wait read: I_ADDR = 0x0000_0100, I_SIZE = 2, I_WRITE = 0; slave returns 0xA0..0xA7 -> NONSEQ at 0x100, then SEQ at 0x104..0x11C, then IDLE; exactly 8 O_DMA_READY pulses with O_RDATA = 0xA0..0xA7; O_ERR = 0.
- Write with waits: I_ADDR = 0x200, I_WRITE = 1; I_HREADY low for 2 cycles on beat 3 -> O_HADDR and O_HWDATA held during the wait; O_HWDATA sequence equals the I_WDATA sequence; 8 pulses; burst takes 2 cycles longer than zero-wait.
- Boundary reject: I_ADDR = 0x3F0, I_SIZE = 2 (burst ends at 0x40F, crossing 1 KB) -> O_ERR pulses once; O_HTRANS stays IDLE throughout; O_DMA_READY never asserted.
- Bus error: ERROR response on beat 5 of a read -> O_HTRANS = IDLE in the first error cycle; O_ERR pulses in the second; exactly 4 O_DMA_READY pulses; O_BUSY = 0 afterwards.
- Reset mid-burst: I_HRESET = 1 during beat 4 -> next cycle all outputs are 0 and O_HTRANS = IDLE; a new request after reset runs a clean 8-beat burst.
- Back-to-back: I_REQ held high for two requests at 0x000 and 0x020 -> two complete INCR8 bursts, 16 pulses total, no overlap between the bursts.
